// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants used by the fetch stage and its queue.
package riscv_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam int          INSTR_W      = 32;
  localparam int          PC_STEP      = 4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef logic [INSTR_W-1:0] instr_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign do_pop    = pop && !empty;
  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_reg[wr_ptr_reg] <= push_data;
  end

  // The issue rule in the parent must make an overflowing write impossible.
  assert property (@(posedge clock) disable iff (!reset) !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: sequential PC issue to imem, in-order response capture into a
// fetch queue, and redirect handling that flushes the queue and squashes stale responses.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              QUEUE_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [31:0]     fetch_instr
);

  localparam int CNT_W = cnt_width(QUEUE_DEPTH);
  // One spare bit: squashed requests from a redirect are tracked on top of a full
  // window of live requests, so the raw in-flight total can exceed QUEUE_DEPTH.
  localparam int TRK_W = CNT_W + 1;
  localparam int ENT_W = XLEN + INSTR_W;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]  req_pc_reg;
  logic [XLEN-1:0]  resp_pc_reg;
  logic [TRK_W-1:0] inflight_reg;
  logic [TRK_W-1:0] drop_cnt_reg;
  logic [TRK_W-1:0] inflight_next;
  logic [TRK_W-1:0] inflight_live;
  logic [TRK_W:0]   occupancy;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;
  logic [ENT_W-1:0] head_data;
  logic             req_fire;
  logic             resp_keep;
  logic             pop;

  fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (resp_keep),
    .push_data ({resp_pc_reg, imem_resp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head_data),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    inflight_live  = inflight_reg - drop_cnt_reg;
    occupancy      = (TRK_W+1)'(q_count) + (TRK_W+1)'(inflight_live);
    imem_req_valid = reset && !redirect_valid && (occupancy < (TRK_W+1)'(QUEUE_DEPTH));
    imem_req_addr  = req_pc_reg;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_keep      = imem_resp_valid && (drop_cnt_reg == '0) && !redirect_valid;
    inflight_next  = inflight_reg + TRK_W'(req_fire) - TRK_W'(imem_resp_valid);
    fetch_valid    = reset && !q_empty;
    pop            = fetch_valid && fetch_ready;
    fetch_pc       = reset ? head_data[ENT_W-1:INSTR_W] : '0;
    fetch_instr    = reset ? head_data[INSTR_W-1:0] : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      req_pc_reg   <= RESET_PC;
      resp_pc_reg  <= RESET_PC;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
      if (redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old path.
        req_pc_reg   <= redirect_target & ALIGN_MASK;
        resp_pc_reg  <= redirect_target & ALIGN_MASK;
        drop_cnt_reg <= inflight_next;
      end else begin
        if (req_fire)  req_pc_reg <= req_pc_reg + XLEN'(PC_STEP);
        if (resp_keep) resp_pc_reg <= resp_pc_reg + XLEN'(PC_STEP);
        else if (imem_resp_valid) drop_cnt_reg <= drop_cnt_reg - 1'b1;
      end
    end
  end

  // Depth bookkeeping only; the queue itself never reports full to the issue logic.
  logic unused_full;
  assign unused_full = q_full;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against an in-order stream model of decode's view.
module tb_fetch_unit;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // main instance (RESET_PC = 0)
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b1;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;

  // wrap instance (RESET_PC = 0xFFFF_FFF8), 1-cycle memory, always ready
  logic        w_reset = 1'b0;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_target = '0;
  logic        w_req_valid;
  logic        w_req_ready = 1'b1;
  logic [31:0] w_req_addr;
  logic        w_resp_valid = 1'b0;
  logic [31:0] w_resp_data = '0;
  logic        w_fetch_valid;
  logic        w_fetch_ready = 1'b1;
  logic [31:0] w_fetch_pc;
  logic [31:0] w_fetch_instr;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .QUEUE_DEPTH(4)) u_dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(4)) u_wrap (
    .clock(clock), .reset(w_reset),
    .redirect_valid(w_redirect_valid), .redirect_target(w_redirect_target),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .fetch_valid(w_fetch_valid), .fetch_ready(w_fetch_ready),
    .fetch_pc(w_fetch_pc), .fetch_instr(w_fetch_instr)
  );

  int checks = 0;
  int errors = 0;

  // memory model state
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  // reference model: next PC decode must see, next PC that must be requested
  logic [31:0] exp_fetch_pc = '0;
  logic [31:0] exp_req_pc = '0;
  logic        hold_pending = 1'b0;
  logic [31:0] hold_addr = '0;

  logic [31:0] pop_log[$];
  logic [31:0] pop_instr_log[$];
  logic [31:0] w_log[$];

  // values sampled in the cycle just completed by tick()
  logic        s_req_valid, s_req_fire, s_resp_valid, s_fetch_valid, s_pop;
  logic        s_redirect, s_reset, s_w_fire, s_w_fetch_valid;
  logic [31:0] s_req_addr, s_fetch_pc, s_fetch_instr, s_target, s_w_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return {addr[31:2], 2'b11} ^ 32'h5A3C_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int due;
    @(negedge clock);
    s_req_valid     = imem_req_valid;
    s_req_addr      = imem_req_addr;
    s_req_fire      = imem_req_valid && imem_req_ready;
    s_resp_valid    = imem_resp_valid;
    s_fetch_valid   = fetch_valid;
    s_fetch_pc      = fetch_pc;
    s_fetch_instr   = fetch_instr;
    s_pop           = fetch_valid && fetch_ready;
    s_redirect      = redirect_valid;
    s_target        = redirect_target;
    s_reset         = reset;
    s_w_fire        = w_req_valid && w_req_ready;
    s_w_addr        = w_req_addr;
    s_w_fetch_valid = w_fetch_valid;
    if (reset) begin
      if (redirect_valid) chk("req_blocked_by_redirect", 32'(imem_req_valid), 32'd0);
      else if (hold_pending) begin
        chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
        chk("req_hold_addr", imem_req_addr, hold_addr);
      end
      if (s_req_fire) chk("req_addr", imem_req_addr, exp_req_pc);
      if (fetch_valid) chk("instr_matches_pc", fetch_instr, instr_of(fetch_pc));
      if (s_pop) begin
        chk("pop_pc", fetch_pc, exp_fetch_pc);
        pop_log.push_back(fetch_pc);
        pop_instr_log.push_back(fetch_instr);
      end
    end
    if (w_reset && w_fetch_valid && w_fetch_ready) w_log.push_back(w_fetch_pc);
    @(posedge clock);
    #1;
    cyc++;
    if (!s_reset) begin
      exp_req_pc   = 32'h0;
      exp_fetch_pc = 32'h0;
      hold_pending = 1'b0;
      last_due     = 0;
      mem_addr_q.delete();
      mem_due_q.delete();
    end else begin
      if (s_pop) exp_fetch_pc += 32'd4;
      if (s_req_fire) begin
        exp_req_pc += 32'd4;
        due = cyc - 1 + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_addr_q.push_back(s_req_addr);
        mem_due_q.push_back(due);
      end
      hold_pending = s_req_valid && !s_req_fire;
      hold_addr    = s_req_addr;
      if (s_redirect) begin
        exp_req_pc   = s_target & 32'hFFFF_FFFC;
        exp_fetch_pc = s_target & 32'hFFFF_FFFC;
        hold_pending = 1'b0;
      end
    end
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (mem_due_q.size() != 0 && mem_due_q[0] == cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    w_resp_valid = s_w_fire;
    w_resp_data  = instr_of(s_w_addr);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_pop(input int budget);
    int n = 0;
    while (pop_log.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    chk("pop_within_budget", 32'(pop_log.size() != 0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;

    // 1: reset state, then one instruction per cycle from 0x0
    lat = 1;
    reset = 1'b0;
    tick();
    tick();
    chk("rst_req_valid", 32'(s_req_valid), 32'd0);
    chk("rst_fetch_valid", 32'(s_fetch_valid), 32'd0);
    chk("rst_fetch_pc", s_fetch_pc, 32'd0);
    chk("rst_fetch_instr", s_fetch_instr, 32'd0);
    reset = 1'b1;
    tick();
    chk("first_req_valid", 32'(s_req_valid), 32'd1);
    chk("first_req_addr", s_req_addr, 32'h0);
    tick();
    chk("fetch_empty_c2", 32'(s_fetch_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stream_valid", 32'(s_fetch_valid), 32'd1);
      chk("stream_pc", s_fetch_pc, 32'(4 * i));
    end

    // 2: decode stalled, queue fills to depth, then drains in order
    fetch_ready = 1'b0;
    do_reset();
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_req_fire) hs++;
    end
    chk("stall_req_count", 32'(hs), 32'd4);
    chk("stall_req_valid", 32'(s_req_valid), 32'd0);
    chk("stall_fetch_valid", 32'(s_fetch_valid), 32'd1);
    chk("stall_fetch_pc", s_fetch_pc, 32'h0);
    pop_log.delete();
    fetch_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < 5; i++)
      chk("drain_order", (pop_log.size() > i) ? pop_log[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // 3: 3-cycle memory, redirect with three requests outstanding
    lat = 3;
    do_reset();
    hs = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (s_req_fire) hs++;
    end
    chk("lat3_inflight", 32'(hs), 32'd3);
    pop_log.delete();
    pop_instr_log.delete();
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    tick();
    chk("redir_no_req", 32'(s_req_valid), 32'd0);
    chk("redir_resp_arrives", 32'(s_resp_valid), 32'd1);
    redirect_valid = 1'b0;
    tick();
    chk("redir_req_addr", s_req_addr, 32'h100);
    wait_pop(30);
    chk("redir_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);
    chk("redir_first_instr", (pop_instr_log.size() > 0) ? pop_instr_log[0] : 32'hDEAD_BEEF,
        instr_of(32'h100));

    // 4+5: unaligned redirect colliding with a pop and a response, latency N+3
    lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h203;
    tick();
    chk("collide_pop", 32'(s_pop), 32'd1);
    chk("collide_resp", 32'(s_resp_valid), 32'd1);
    chk("collide_no_req", 32'(s_req_valid), 32'd0);
    redirect_valid = 1'b0;
    tick();
    chk("n1_fetch_empty", 32'(s_fetch_valid), 32'd0);
    chk("n1_req_addr", s_req_addr, 32'h200);
    chk("n1_req_valid", 32'(s_req_valid), 32'd1);
    tick();
    chk("n2_fetch_empty", 32'(s_fetch_valid), 32'd0);
    tick();
    chk("n3_fetch_valid", 32'(s_fetch_valid), 32'd1);
    chk("n3_fetch_pc", s_fetch_pc, 32'h200);

    // 6: RESET_PC near the top of the address space, then reset mid-stream
    w_reset = 1'b1;
    w_log.delete();
    for (int i = 0; i < 8; i++) tick();
    chk("wrap_pc0", (w_log.size() > 0) ? w_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    chk("wrap_pc1", (w_log.size() > 1) ? w_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_pc2", (w_log.size() > 2) ? w_log[2] : 32'hDEAD_BEEF, 32'h0000_0000);
    chk("wrap_streaming", 32'(s_w_fetch_valid), 32'd1);
    w_reset = 1'b0;
    tick();
    chk("wrap_rst_valid", 32'(s_w_fetch_valid), 32'd0);
    w_reset = 1'b1;
    w_log.delete();
    tick();
    chk("wrap_after_rst_valid", 32'(s_w_fetch_valid), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("wrap_refetch_pc", (w_log.size() > 0) ? w_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);

    // randomized traffic per memory latency
    for (int l = 1; l <= 3; l++) begin
      lat = l;
      fetch_ready = 1'b1;
      imem_req_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 600; i++) begin
        imem_req_ready  = ($urandom % 4) != 0;
        fetch_ready     = ($urandom % 3) != 0;
        redirect_valid  = ($urandom % 40) == 0;
        redirect_target = $urandom;
        tick();
      end
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      fetch_ready = 1'b1;
      pop_log.delete();
      wait_pop(20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
